// File: rtl/nlfsr_keystream_gen_pkg.sv
// Shared definitions for the nonlinear keystream generator tile.
// Holds the FSM state encoding, the default warmup length, the constant
// used to escape the all-zero state, and the 2-bit nonlinear filter
// function. The downstream filter tile's model reuses that function.
package nlfsr_keystream_gen_pkg;

  // The 3-bit codes are exposed directly on io_out[7:5].
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_LO = 3'd1,
    ST_WARMUP  = 3'd2,
    ST_RUN     = 3'd3,
    ST_HOLD    = 3'd4
  } ks_state_e;

  localparam int         WARMUP_DEFAULT = 16;
  localparam logic [7:0] ZERO_FIX       = 8'h01;

  // Filter outputs {f1,f0} for a given shift state.
  function automatic logic [1:0] nlf_filter(input logic [7:0] s);
    logic f0;
    logic f1;
    f0 = s[0] ^ (~s[1] & s[3]) ^ (s[1] & s[2]) ^ (s[3] & s[4]);
    f1 = s[5] ^ (s[2] & ~s[4]) ^ (s[2] & s[6]) ^ (s[4] & s[7]);
    return {f1, f0};
  endfunction

endpackage

// File: rtl/nlfsr_step.sv
// Combinational single step of the nonlinear shift register.
// Ports:
//   s        in   current 8-bit state
//   s_next   out  next state, with the all-zero state replaced by ZERO_FIX
//   ks       out  filter outputs {f1,f0} of the current state
//   zero_fix out  high when the raw next state was zero and got replaced
module nlfsr_step
  import nlfsr_keystream_gen_pkg::*;
(
  input  logic [7:0] s,
  output logic [7:0] s_next,
  output logic [1:0] ks,
  output logic       zero_fix
);

  logic [7:0] raw_next;

  // Shift left by two; the two new low bits fold the filter outputs back
  // into the bits that are shifted out.
  always_comb begin
    ks       = nlf_filter(s);
    raw_next = {s[5:0], s[7] ^ ks[1], s[6] ^ ks[0]};
    zero_fix = (raw_next == 8'h00);
    s_next   = zero_fix ? ZERO_FIX : raw_next;
  end

endmodule

// File: rtl/nlfsr_keystream_gen.sv
// Keystream generator tile: loads an 8-bit seed as two nibbles, runs a
// configurable number of discarded warmup steps, then emits the registered
// filter outputs as a 2-bit-per-cycle keystream.
// Ports (8-in/8-out user tile):
//   io_in[0]    clock
//   io_in[1]    rst_n, asynchronous, active-low
//   io_in[2]    load_en, start a seed load (high nibble on this edge)
//   io_in[3]    run, step enable while running
//   io_in[7:4]  seed nibble, high nibble first then low nibble
//   io_out[1:0] keystream {f1,f0}, registered
//   io_out[2]   ks_valid
//   io_out[3]   lockup, sticky, set when the zero state had to be replaced
//   io_out[4]   busy, high in LOAD_LO or WARMUP
//   io_out[7:5] FSM state code
module nlfsr_keystream_gen
  import nlfsr_keystream_gen_pkg::*;
#(
  parameter int WARMUP = WARMUP_DEFAULT
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  // The counter is only 4 bits wide, so a 16-step warmup starts at 15.
  localparam logic [3:0] COUNT_START = (WARMUP == 0) ? 4'd0 : 4'(WARMUP - 1);

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic       run;
  logic [3:0] seed;

  assign clk     = io_in[0];
  assign rst_n   = io_in[1];
  assign load_en = io_in[2];
  assign run     = io_in[3];
  assign seed    = io_in[7:4];

  ks_state_e  state, state_d;
  logic [7:0] s, s_d;
  logic [3:0] counter, counter_d;
  logic [1:0] ks_q, ks_d;
  logic       ks_valid_q, ks_valid_d;
  logic       lockup_q, lockup_d;

  logic [7:0] step_next;
  logic [1:0] step_ks;
  logic       step_zero;
  logic [7:0] loaded;

  nlfsr_step u_step (
    .s        (s),
    .s_next   (step_next),
    .ks       (step_ks),
    .zero_fix (step_zero)
  );

  assign loaded = {s[7:4], seed};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      s          <= 8'h00;
      counter    <= 4'd0;
      ks_q       <= 2'b00;
      ks_valid_q <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      state      <= state_d;
      s          <= s_d;
      counter    <= counter_d;
      ks_q       <= ks_d;
      ks_valid_q <= ks_valid_d;
      lockup_q   <= lockup_d;
    end
  end

  // A load request outranks everything except an in-progress LOAD_LO, so it
  // is checked before the per-state behaviour. ks_valid drops to zero unless
  // a keystream step actually happens on this edge.
  always_comb begin
    state_d    = state;
    s_d        = s;
    counter_d  = counter;
    ks_d       = ks_q;
    ks_valid_d = 1'b0;
    lockup_d   = lockup_q;

    if (load_en && (state != ST_LOAD_LO)) begin
      s_d      = {seed, 4'h0};
      lockup_d = 1'b0;
      state_d  = ST_LOAD_LO;
    end else begin
      case (state)
        ST_IDLE: state_d = ST_IDLE;
        ST_LOAD_LO: begin
          s_d = loaded;
          if (loaded == 8'h00) begin
            s_d      = ZERO_FIX;
            lockup_d = 1'b1;
          end
          counter_d = COUNT_START;
          state_d   = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end
        ST_WARMUP: begin
          s_d = step_next;
          if (step_zero) lockup_d = 1'b1;
          if (counter == 4'd0) state_d = ST_RUN;
          else                 counter_d = counter - 4'd1;
        end
        ST_RUN, ST_HOLD: begin
          if (run) begin
            s_d        = step_next;
            ks_d       = step_ks;
            ks_valid_d = 1'b1;
            if (step_zero) lockup_d = 1'b1;
            state_d    = ST_RUN;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign io_out = {state, (state == ST_LOAD_LO) || (state == ST_WARMUP),
                   lockup_q, ks_valid_q, ks_q};

endmodule
